// File: rtl/hdmi_tmds_encoder.sv
// TMDS encoder for three video channels (DVI 8b/10b) with an optional
// HDMI video preamble and guard band ahead of every eligible active line.
module hdmi_tmds_encoder #(
    parameter int HDMI_MODE = 1,
    parameter int PRE_LEN   = 8,
    parameter int GB_LEN    = 2
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [23:0] video_din,
    input  logic        video_hsync,
    input  logic        video_vsync,
    input  logic        video_de,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic        de_out,
    output logic        short_blank
);

    localparam int         LA      = (HDMI_MODE != 0) ? PRE_LEN + GB_LEN : 0;
    localparam logic [4:0] LA5     = 5'(LA);
    localparam logic [3:0] PRE_END = 4'(PRE_LEN - 1);
    localparam logic [3:0] GB_END  = 4'(GB_LEN - 1);
    localparam logic [9:0] CTL_00  = 10'b1101010100;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_GUARD} state_t;

    function automatic logic [9:0] f_ctl(input logic [1:0] c);
        case (c)
            2'b00:   f_ctl = 10'b1101010100;
            2'b01:   f_ctl = 10'b0010101011;
            2'b10:   f_ctl = 10'b0101010100;
            default: f_ctl = 10'b1010101011;
        endcase
    endfunction

    function automatic logic [8:0] f_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       xn;
        logic [8:0] q;
        n1 = '0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
        xn   = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xn;
        return q;
    endfunction

    logic        r_prev_de;
    logic [4:0]  r_blank;
    state_t      r_state, w_nstate;
    logic [3:0]  r_cnt, w_ncnt;
    logic        w_rise, w_ok, w_start, w_sb;

    assign w_rise  = video_de & ~r_prev_de;
    assign w_ok    = (HDMI_MODE != 0) && (r_blank == LA5) && (r_state == S_IDLE);
    assign w_start = w_rise & w_ok;
    assign w_sb    = w_rise & ~w_ok & (HDMI_MODE != 0);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_prev_de <= 1'b0;
            r_blank   <= LA5;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
        end else begin
            r_prev_de <= video_de;
            if (video_de)
                r_blank <= '0;
            else if (r_blank != LA5)
                r_blank <= r_blank + 5'd1;
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
        end
    end

    // Preamble starts the cycle after the rise so the last guard lands just before the pixel
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nstate = S_PRE;
                    w_ncnt   = '0;
                end
            end
            S_PRE: begin
                if (r_cnt == PRE_END) begin
                    w_nstate = S_GUARD;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 4'd1;
                end
            end
            S_GUARD: begin
                if (r_cnt == GB_END) begin
                    w_nstate = S_IDLE;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_ncnt   = '0;
            end
        endcase
    end

    logic [27:0] w_tap, w_dly;
    assign w_tap = {w_sb, video_de, video_vsync, video_hsync, video_din};

    if (LA == 0) begin : g_nodly
        assign w_dly = w_tap;
    end else begin : g_dly
        logic [27:0] r_dly [LA];
        always_ff @(posedge pclk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LA; i++) r_dly[i] <= '0;
            end else begin
                r_dly[0] <= w_tap;
                for (int i = 1; i < LA; i++) r_dly[i] <= r_dly[i-1];
            end
        end
        assign w_dly = r_dly[LA-1];
    end

    logic [8:0] r_qm [3];
    logic       r_de1, r_hs1, r_vs1, r_sb1;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_qm[i] <= '0;
            r_de1 <= 1'b0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
            r_sb1 <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) r_qm[i] <= f_qm(w_dly[8*i +: 8]);
            r_de1 <= w_dly[26];
            r_vs1 <= w_dly[25];
            r_hs1 <= w_dly[24];
            r_sb1 <= w_dly[27];
        end
    end

    logic w_pre, w_gb;
    assign w_pre = (r_state == S_PRE);
    assign w_gb  = (r_state == S_GUARD);

    for (genvar g = 0; g < 3; g++) begin : g_ch
        localparam logic [9:0] GUARD = (g == 1) ? 10'b0100110011 : 10'b1011001100;
        logic [8:0]        w_qm;
        logic [3:0]        w_n1;
        logic signed [5:0] w_bal, w_two, w_ndisp, r_disp;
        logic [1:0]        w_ctl;
        logic [9:0]        w_sym, r_out;

        assign w_qm = r_qm[g];

        // Running disparity is kept as ones minus zeros of the emitted symbols
        always_comb begin
            w_n1 = '0;
            for (int b = 0; b < 8; b++) w_n1 = w_n1 + {3'b000, w_qm[b]};
            w_bal   = $signed({1'b0, w_n1, 1'b0}) - 6'sd8;
            w_two   = w_qm[8] ? 6'sd2 : 6'sd0;
            w_sym   = '0;
            w_ndisp = r_disp;
            if (r_disp == 6'sd0 || w_n1 == 4'd4) begin
                w_sym   = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
                w_ndisp = w_qm[8] ? r_disp + w_bal : r_disp - w_bal;
            end else if (r_disp[5] == (w_n1 < 4'd4)) begin
                w_sym   = {1'b1, w_qm[8], ~w_qm[7:0]};
                w_ndisp = r_disp + w_two - w_bal;
            end else begin
                w_sym   = {1'b0, w_qm[8], w_qm[7:0]};
                w_ndisp = r_disp + w_two - 6'sd2 + w_bal;
            end
            w_ctl = 2'b00;
            if (g == 0)
                w_ctl = {r_vs1, r_hs1};
            else if (w_pre)
                w_ctl = 2'b01;
        end

        always_ff @(posedge pclk or posedge reset) begin
            if (reset) begin
                r_disp <= '0;
                r_out  <= CTL_00;
            end else if (w_gb) begin
                r_disp <= '0;
                r_out  <= GUARD;
            end else if (r_de1) begin
                r_disp <= w_ndisp;
                r_out  <= w_sym;
            end else begin
                r_disp <= '0;
                r_out  <= f_ctl(w_ctl);
            end
        end
    end

    logic r_de_o, r_sb_o;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_de_o <= 1'b0;
            r_sb_o <= 1'b0;
        end else begin
            r_de_o <= r_de1 & ~w_gb;
            r_sb_o <= r_sb1;
        end
    end

    assign tmds_ch0    = g_ch[0].r_out;
    assign tmds_ch1    = g_ch[1].r_out;
    assign tmds_ch2    = g_ch[2].r_out;
    assign de_out      = r_de_o;
    assign short_blank = r_sb_o;

endmodule
